// File: rtl/brick_map_store.sv
// Registered 20x24 brick array: level loads, per-frame collision commits, pixel reads, brick count scan.
// Optional BRICK_HP_EN: a hit decrements a cell's hit points instead of clearing it.
module brick_map_store #(
    parameter int unsigned COLS  = 20,
    parameter int unsigned ROWS  = 24,
    parameter int unsigned CELLS = COLS * ROWS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           state_i,
    input  logic                 frame_tick_i,
    input  logic                 level_load_i,
    input  logic [1:0]           level_sel_i,
    input  logic [3*CELLS-1:0]   next_bricks_i,
    input  logic                 collision_trig_i,
    input  logic [9:0]           h_cnt_i,
    input  logic [9:0]           v_cnt_i,
    output logic [3*CELLS-1:0]   bricks_o,
    output logic [2:0]           pix_brick_o,
    output logic [8:0]           bricks_left_o,
    output logic                 count_valid_o,
    output logic                 level_clear_o
);

    typedef enum logic [1:0] {StIdle, StRun, StScan} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [3*CELLS-1:0] bricks_q, bricks_d;
    logic [8:0]         scan_idx_q, scan_idx_d;
    logic [8:0]         acc_q, acc_d;
    logic [8:0]         left_q, left_d;
    logic               valid_q, valid_d;
    logic [2:0]         pix_q, pix_d;

    logic [3*CELLS-1:0] load_pattern;
    logic [3*CELLS-1:0] commit_val;
    logic [10:0]        scan_off;
    logic               scan_hit;
    logic               commit;
    logic [9:0]         pix_row;
    logic [8:0]         pix_idx;
    logic [10:0]        pix_off;

    function automatic logic [2:0] pattern_cell(input logic [1:0] sel, input int unsigned row,
                                                 input int unsigned col);
        logic [2:0] val;
        val = 3'd0;
        unique case (sel)
            2'd0: if (row >= 2 && row <= 7) val = 3'd1;
            2'd1: if (row >= 2 && row <= 9 && ((row + col) % 2) == 0) val = 3'd2;
            2'd2: begin
                if (row >= 2 && row <= 5)      val = 3'd3;
                else if (row >= 6 && row <= 9) val = 3'd1;
            end
            2'd3: if (row >= 2 && row <= 11) val = 3'd7;
        endcase
        return val;
    endfunction

    always_comb begin
        load_pattern = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                load_pattern[3*(c+COLS*r) +: 3] = pattern_cell(level_sel_i, r, c);
            end
        end
    end

`ifdef BRICK_HP_EN
    // A hit (proposed empty over a live cell) costs one hit point; all else is taken verbatim.
    always_comb begin
        commit_val = next_bricks_i;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (bricks_q[3*i +: 3] != 3'd0 && next_bricks_i[3*i +: 3] == 3'd0) begin
                commit_val[3*i +: 3] = bricks_q[3*i +: 3] - 3'd1;
            end
        end
    end
`else
    assign commit_val = next_bricks_i;
`endif

    assign scan_off = {2'b00, scan_idx_q} * 11'd3;
    assign scan_hit = |bricks_q[scan_off +: 3];
    assign commit   = (fsm_q != StIdle) && frame_tick_i && collision_trig_i && (state_i != 3'd0);

    always_comb begin
        fsm_d      = fsm_q;
        bricks_d   = bricks_q;
        scan_idx_d = scan_idx_q;
        acc_d      = acc_q;
        left_d     = left_q;
        valid_d    = valid_q;
        if (level_load_i || commit) begin
            // Load wins over a same-cycle commit; either one restarts the count from cell 0.
            bricks_d   = level_load_i ? load_pattern : commit_val;
            fsm_d      = StScan;
            scan_idx_d = 9'd0;
            acc_d      = 9'd0;
            valid_d    = 1'b0;
        end else if (fsm_q == StScan) begin
            if (scan_idx_q == 9'(CELLS - 1)) begin
                left_d  = acc_q + {8'd0, scan_hit};
                valid_d = 1'b1;
                fsm_d   = StRun;
            end else begin
                acc_d      = acc_q + {8'd0, scan_hit};
                scan_idx_d = scan_idx_q + 9'd1;
            end
        end
    end

    always_comb begin
        pix_row = v_cnt_i / 10'd20;
        pix_idx = {4'd0, h_cnt_i[9:5]} + 9'(pix_row) * 9'd20;
        pix_off = {2'b00, pix_idx} * 11'd3;
        pix_d   = 3'd0;
        if (h_cnt_i < 10'd640 && v_cnt_i < 10'd480) begin
            pix_d = bricks_q[pix_off +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= StIdle;
            bricks_q   <= '0;
            scan_idx_q <= 9'd0;
            acc_q      <= 9'd0;
            left_q     <= 9'd0;
            valid_q    <= 1'b0;
            pix_q      <= 3'd0;
        end else begin
            fsm_q      <= fsm_d;
            bricks_q   <= bricks_d;
            scan_idx_q <= scan_idx_d;
            acc_q      <= acc_d;
            left_q     <= left_d;
            valid_q    <= valid_d;
            pix_q      <= pix_d;
        end
    end

    assign bricks_o      = bricks_q;
    assign pix_brick_o   = pix_q;
    assign bricks_left_o = left_q;
    assign count_valid_o = valid_q;
    assign level_clear_o = valid_q && (left_q == 9'd0);

endmodule

// File: tb/tb_brick_map_store.sv
// Randomized bench for brick_map_store against a cell-array reference model.
// Honours BRICK_HP_EN the same way the design does.
module tb_brick_map_store;

    localparam int Cells = 480;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        state;
    logic              frame_tick;
    logic              level_load;
    logic [1:0]        level_sel;
    logic [1439:0]     next_bricks;
    logic              collision_trig;
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [1439:0]     bricks;
    logic [2:0]        pix_brick;
    logic [8:0]        bricks_left;
    logic              count_valid;
    logic              level_clear;

    always #5 clk = ~clk;

    brick_map_store dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .state_i          (state),
        .frame_tick_i     (frame_tick),
        .level_load_i     (level_load),
        .level_sel_i      (level_sel),
        .next_bricks_i    (next_bricks),
        .collision_trig_i (collision_trig),
        .h_cnt_i          (h_cnt),
        .v_cnt_i          (v_cnt),
        .bricks_o         (bricks),
        .pix_brick_o      (pix_brick),
        .bricks_left_o    (bricks_left),
        .count_valid_o    (count_valid),
        .level_clear_o    (level_clear)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain cell array plus a countdown to the end of the current count.
    int m_cells[Cells];
    int scan_rem;
    bit m_valid;
    int m_left;
    bit m_active;
    int exp_pix;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pat(input int sel, input int r, input int c);
        case (sel)
            0: return (r >= 2 && r <= 7) ? 1 : 0;
            1: return (r >= 2 && r <= 9 && ((r + c) % 2) == 0) ? 2 : 0;
            2: return (r >= 2 && r <= 5) ? 3 : ((r >= 6 && r <= 9) ? 1 : 0);
            default: return (r >= 2 && r <= 11) ? 7 : 0;
        endcase
    endfunction

    function automatic int count_nz();
        int n = 0;
        for (int i = 0; i < Cells; i++) if (m_cells[i] != 0) n++;
        return n;
    endfunction

    function automatic logic [1439:0] model_packed();
        logic [1439:0] v = '0;
        for (int i = 0; i < Cells; i++) v[3*i +: 3] = 3'(m_cells[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Cells; i++) m_cells[i] = 0;
        scan_rem = 0;
        m_valid  = 0;
        m_left   = 0;
        m_active = 0;
        exp_pix  = 0;
    endtask

    task automatic model_edge();
        int h = int'(h_cnt);
        int v = int'(v_cnt);
        int nb;
        exp_pix = (h < 640 && v < 480) ? m_cells[h/32 + 20*(v/20)] : 0;
        if (scan_rem > 0) begin
            scan_rem--;
            if (scan_rem == 0) begin
                m_valid = 1;
                m_left  = count_nz();
            end
        end
        if (level_load) begin
            for (int i = 0; i < Cells; i++) m_cells[i] = pat(int'(level_sel), i / 20, i % 20);
            m_active = 1;
            scan_rem = Cells;
            m_valid  = 0;
        end else if (m_active && frame_tick && collision_trig && state != 3'd0) begin
            for (int i = 0; i < Cells; i++) begin
                nb = int'(next_bricks[3*i +: 3]);
`ifdef BRICK_HP_EN
                if (m_cells[i] != 0 && nb == 0) m_cells[i] = m_cells[i] - 1;
                else m_cells[i] = nb;
`else
                m_cells[i] = nb;
`endif
            end
            scan_rem = Cells;
            m_valid  = 0;
        end
    endtask

    task automatic check_all();
        int idx = 0;
        for (int i = Cells - 1; i >= 0; i--) if (bricks[3*i +: 3] !== 3'(m_cells[i])) idx = i;
        check_eq($sformatf("bricks[%0d]", idx), 32'(bricks[3*idx +: 3]), m_cells[idx]);
        check_eq("count_valid", 32'(count_valid), 32'(m_valid));
        check_eq("level_clear", 32'(level_clear), 32'(m_valid && m_left == 0));
        check_eq("bricks_left", 32'(bricks_left), m_left);
        check_eq("pix_brick", 32'(pix_brick), exp_pix);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            h_cnt = 10'($urandom_range(0, 700));
            v_cnt = 10'($urandom_range(0, 520));
            tick();
        end
    endtask

    task automatic load(input int sel);
        level_sel  = 2'(sel);
        level_load = 1'b1;
        tick();
        level_load = 1'b0;
    endtask

    task automatic commit(input logic [2:0] st, input logic [1439:0] nb);
        state          = st;
        next_bricks    = nb;
        frame_tick     = 1'b1;
        collision_trig = 1'b1;
        tick();
        frame_tick     = 1'b0;
        collision_trig = 1'b0;
        state          = 3'd1;
    endtask

    logic [1439:0] nb;
    int            k;

    initial begin
        rst_n = 1'b0; state = 3'd1; frame_tick = 1'b0; level_load = 1'b0; level_sel = 2'd0;
        next_bricks = '0; collision_trig = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Commit before any load is ignored.
        commit(3'd1, {1440{1'b1}});
        run(3);

        load(0);
        run(480);
        check_eq("left_lvl0", 32'(bricks_left), 120);
        check_eq("valid_lvl0", 32'(count_valid), 1);
        check_eq("cell40_lvl0", 32'(bricks[120 +: 3]), 1);

        load(1);
        run(480);
        check_eq("left_lvl1", 32'(bricks_left), 80);
        h_cnt = 10'd0; v_cnt = 10'd40;
        tick();
        check_eq("pix_c0r2_lvl1", 32'(pix_brick), 2);
        h_cnt = 10'd640;
        tick();
        check_eq("pix_h640", 32'(pix_brick), 0);

`ifdef BRICK_HP_EN
        load(2);
        run(480);
        nb = bricks;
        nb[135 +: 3] = 3'd0;
        commit(3'd1, nb);
        run(480);
        check_eq("hp_cell45", 32'(bricks[135 +: 3]), 2);
        check_eq("hp_left", 32'(bricks_left), 160);
`else
        load(0);
        run(480);
        nb = bricks;
        nb[135 +: 3] = 3'd0;
        commit(3'd1, nb);
        run(480);
        check_eq("cell45_hit", 32'(bricks[135 +: 3]), 0);
        check_eq("left_after_hit", 32'(bricks_left), 119);
`endif

        // Commit with game state MENU is blocked.
        nb = model_packed();
        nb[150 +: 3] = 3'd0;
        commit(3'd0, nb);
        check_eq("menu_valid", 32'(count_valid), 1);
        run(5);

        // Commit mid-scan restarts the count.
        nb = model_packed();
        nb[180 +: 3] = 3'd0;
        commit(3'd1, nb);
        run(199);
        nb = model_packed();
        nb[183 +: 3] = 3'd0;
        commit(3'd1, nb);
        run(479);
        check_eq("restart_not_valid", 32'(count_valid), 0);
        run(1);
        check_eq("restart_valid", 32'(count_valid), 1);

        // Load coincident with a commit: pattern wins.
        level_sel = 2'd3; level_load = 1'b1; frame_tick = 1'b1; collision_trig = 1'b1;
        next_bricks = '0;
        tick();
        level_load = 1'b0; frame_tick = 1'b0; collision_trig = 1'b0;
        run(480);
        check_eq("load_wins_left", 32'(bricks_left), 200);

        load(0);
        run(480);
        commit(3'd1, '0);
        run(480);
        check_eq("clear_flag", 32'(level_clear), 1);
        check_eq("clear_left", 32'(bricks_left), 0);

        // Random commits at random scan points.
        load(int'($urandom_range(0, 3)));
        repeat (6) begin
            run(int'($urandom_range(0, 480)));
            nb = model_packed();
            repeat ($urandom_range(1, 30)) begin
                k = int'($urandom_range(0, Cells - 1));
                nb[3*k +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            end
            commit(3'($urandom_range(0, 7)), nb);
        end
        run(481);

        // Asynchronous reset mid-scan.
        load(3);
        run(100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("rst_bricks_zero", 32'(bricks != '0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(0);
        run(480);
        check_eq("left_after_rst", 32'(bricks_left), 120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
